gb_mbc1: RTL and testbench
==========================

Name: gb_mbc1

Overview:
- Cartridge-side responder for the console's cartridge bus: a MBC1 memory bank controller plus its ROM/RAM address translation.
- Receives the console's cart_addr/cart_rd/cart_wr/cart_di strobes and decodes mapper register writes.
- Translates 16-bit CPU addresses into physical ROM/external-RAM addresses, drives the attached synchronous memories and returns read data on cart_do.
- Sits between the console core and the board memory (SDRAM-backed ROM, BRAM cart RAM).

Parameters:
ROM_AW, 21, physical ROM address width (2 MB max, 128 banks of 16 KB)
RAM_AW, 15, physical cart RAM address width (32 KB max, 4 banks of 8 KB)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cart_addr  in  16  CPU-side cartridge address
cart_rd  in  1  read strobe (level, may span several cycles)
cart_wr  in  1  write strobe (level, may span several cycles)
cart_di  in  8  write data from console
cart_do  out  8  read data to console
rom_mask  in  7  ROM bank mask from header size (e.g. 7'h1F = 32 banks)
ram_mask  in  2  RAM bank mask (2'b00 = single bank / none)
ram_present  in  1  cart has external RAM
rom_addr  out  ROM_AW  physical ROM address
rom_rd  out  1  ROM read enable
rom_q  in  8  ROM data, valid 1 cycle after rom_addr/rom_rd
ram_addr  out  RAM_AW  physical RAM address
ram_we  out  1  RAM write enable
ram_d  out  8  RAM write data
ram_q  in  8  RAM data, valid 1 cycle after ram_addr

Behaviour:
- Clocking and reset: clk, reset; reset is synchronous, active-high.
- State: ram_en (1b), bank1 (5b raw), bank2 (2b), mode (1b), wr_d (1b, previous cart_wr), rsel (2b, registered read source).
- Reset values: ram_en=0, bank1=0, bank2=0, mode=0, wr_d=1, rsel=NONE.
- Reset output values: cart_do=8'hFF, ram_we=0, rom_rd=0.
- Register write fires on the write edge (cart_wr && !wr_d), one update per strobe regardless of its length.
- wr_d resets to 1, so a write held across reset release is ignored.
- No register update while reset is asserted.
- Write decode on edge, by cart_addr[15:13]:
  - 000: ram_en <= (cart_di[3:0]==4'hA).
  - 001: bank1 <= cart_di[4:0].
  - 010: bank2 <= cart_di[1:0].
  - 011: mode <= cart_di[0].
  - 101: no register effect; handled by the RAM path.
  - Other regions: ignored.
- Effective bank1 (bank1_eff) = (bank1==0) ? 1 : bank1. The zero test uses all 5 bits, so 8'h20 written to bank1 gives bank1_eff=1 and the selected bank becomes {bank2,5'b00001}.
- ROM bank, combinational:
  - cart_addr 0000-3FFF: bank = mode ? {bank2,5'b0} : 0.
  - cart_addr 4000-7FFF: bank = {bank2, bank1_eff}.
  - rom_addr = {bank & rom_mask, cart_addr[13:0]}; out-of-range banks wrap via the mask.
- rom_rd = cart_rd && !cart_addr[15].
- RAM path:
  - ram_bank = mode ? bank2 : 0.
  - ram_addr = {ram_bank & ram_mask, cart_addr[12:0]}.
  - ram_d = cart_di.
  - ram_we = cart_wr && (cart_addr[15:13]==3'b101) && ram_en && ram_present && !reset.
  - ram_we is level-asserted every cycle of the strobe (idempotent).
- Read return:
  - Each cycle, rsel <= ROM if !cart_addr[15]; RAM if A000-BFFF && ram_en && ram_present; else NONE.
  - cart_do = rsel==ROM ? rom_q : rsel==RAM ? ram_q : 8'hFF.
  - Latency is 1 cycle from address to valid cart_do; data stays valid while the address is stable.
- Simultaneous events: a register write and a read in the same cycle use the pre-write bank registers for that cycle's address. The new mapping applies from the next cycle.
- A RAM-disable write (ram_en -> 0) during a held RAM write strobe stops ram_we from the next cycle.
- Mask changes take effect combinationally and do not alter the stored registers.

Test Plan:
- Reset, then read 4000 -> rom_addr=21'h004000 (bank 1), cart_do=rom_q next cycle; read 0000 -> rom_addr=0.
- Write 2000<=8'h00, then 8'h20, then 8'h1F with rom_mask=7'h7F, bank2=0 -> 4000 maps to bank 1, 1, 31 (rom_addr 0x04000, 0x04000, 0x7C000).
- Write 4000<=2'b10, 2000<=5, mode=1, rom_mask=7'h7F:
  - 0000 -> bank 64 (0x100000); 4000 -> bank 69 (0x114000).
  - With rom_mask=7'h3F, 4000 -> bank 5 (0x014000).
- RAM access:
  - Write A123 with ram_en=0 -> ram_we never asserts, read A123 returns 8'hFF.
  - Then write 0000<=8'h0A, mode=1, bank2=3, ram_mask=3 -> A123 write gives ram_addr=15'h6123, ram_we high for the whole strobe; read returns ram_q.
- Hold cart_wr 4 cycles on 2000 with cart_di changing 3->7 mid-strobe -> bank1=3 (edge only).
- Assert reset for 1 cycle mid-strobe -> all registers at reset values, no update on release while cart_wr is still high.

Source files
------------

// File: rtl/gb_mbc1.sv
// gb_mbc1: MBC1 cartridge mapper. It decodes mapper register writes from the
// console bus and translates CPU addresses into physical ROM and cart-RAM
// addresses. Read data is returned one cycle after the address is presented.
module gb_mbc1 #(
  parameter int ROM_AW = 21,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cart_addr,
  input  logic              cart_rd,
  input  logic              cart_wr,
  input  logic [7:0]        cart_di,
  output logic [7:0]        cart_do,
  input  logic [6:0]        rom_mask,
  input  logic [1:0]        ram_mask,
  input  logic              ram_present,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_q,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_d,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_ROM  = 2'd1,
    RSEL_RAM  = 2'd2
  } rsel_t;

  logic       ram_en;
  logic [4:0] bank1;
  logic [1:0] bank2;
  logic       mode;
  logic       wr_d;
  rsel_t      rsel, rsel_nxt;

  logic       wr_edge;
  logic       in_ram_win;
  logic [4:0] bank1_eff;
  logic [6:0] rom_bank;
  logic [1:0] ram_bank;
  logic [20:0] rom_full;
  logic [14:0] ram_full;

  assign wr_edge    = cart_wr && !wr_d;
  assign in_ram_win = (cart_addr[15:13] == 3'b101);

  // Mapper registers: one update per write strobe, taken on its rising edge.
  // wr_d resets high so a strobe still held when reset drops is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en <= 1'b0;
      bank1  <= 5'd0;
      bank2  <= 2'd0;
      mode   <= 1'b0;
      wr_d   <= 1'b1;
      rsel   <= RSEL_NONE;
    end else begin
      wr_d <= cart_wr;
      rsel <= rsel_nxt;
      if (wr_edge) begin
        case (cart_addr[15:13])
          3'b000:  ram_en <= (cart_di[3:0] == 4'hA);
          3'b001:  bank1  <= cart_di[4:0];
          3'b010:  bank2  <= cart_di[1:0];
          3'b011:  mode   <= cart_di[0];
          default: ;
        endcase
      end
    end
  end

  // Read source for the next cycle, registered so cart_do lines up with the
  // one-cycle latency of the attached synchronous memories.
  always_comb begin
    rsel_nxt = RSEL_NONE;
    if (!cart_addr[15])
      rsel_nxt = RSEL_ROM;
    else if (in_ram_win && ram_en && ram_present)
      rsel_nxt = RSEL_RAM;
  end

  // ROM bank selection; a raw bank1 of zero (all five bits) reads as bank 1.
  always_comb begin
    bank1_eff = (bank1 == 5'd0) ? 5'd1 : bank1;
    if (!cart_addr[14])
      rom_bank = mode ? {bank2, 5'd0} : 7'd0;
    else
      rom_bank = {bank2, bank1_eff};
    ram_bank = mode ? bank2 : 2'd0;
  end

  assign rom_full = {rom_bank & rom_mask, cart_addr[13:0]};
  assign ram_full = {ram_bank & ram_mask, cart_addr[12:0]};
  assign rom_addr = ROM_AW'(rom_full);
  assign ram_addr = RAM_AW'(ram_full);
  assign rom_rd   = cart_rd && !cart_addr[15] && !reset;
  assign ram_d    = cart_di;
  // Level write enable: repeated writes of the same byte are harmless, and a
  // disable of ram_en cuts the strobe off from the following cycle.
  assign ram_we   = cart_wr && in_ram_win && ram_en && ram_present && !reset;

  // Return data from whichever memory was addressed last cycle.
  always_comb begin
    case (rsel)
      RSEL_ROM: cart_do = rom_q;
      RSEL_RAM: cart_do = ram_q;
      default:  cart_do = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_gb_mbc1.sv
// tb_gb_mbc1: directed and random checks of gb_mbc1 against a behavioural
// model of the MBC1 mapping rules, with small ROM/RAM memory models attached.
module tb_gb_mbc1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cart_addr;
  logic        cart_rd, cart_wr;
  logic [7:0]  cart_di, cart_do;
  logic [6:0]  rom_mask;
  logic [1:0]  ram_mask;
  logic        ram_present;
  logic [20:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_q;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_d, ram_q;

  int chk = 0;
  int err = 0;

  // reference model state
  int         m_ram_en, m_bank1, m_bank2, m_mode;
  logic [7:0] model_ram [0:32767];
  logic [7:0] ram_mem   [0:32767];

  gb_mbc1 #(.ROM_AW(21), .RAM_AW(15)) dut (
    .clk(clk), .reset(reset), .cart_addr(cart_addr), .cart_rd(cart_rd),
    .cart_wr(cart_wr), .cart_di(cart_di), .cart_do(cart_do),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .ram_present(ram_present),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_data(int pa);
    return 8'((pa ^ (pa >> 7) ^ (pa >> 14)) & 255);
  endfunction

  // synchronous ROM and RAM, one cycle read latency
  always @(posedge clk) rom_q <= rom_data(int'(rom_addr));
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_d;
    ram_q <= ram_mem[ram_addr];
  end

  function automatic int exp_rom(int a);
    int bank, b1;
    b1 = (m_bank1 == 0) ? 1 : m_bank1;
    if (a >= 'h4000) bank = m_bank2 * 32 + b1;
    else             bank = m_mode ? m_bank2 * 32 : 0;
    return (bank & int'(rom_mask)) * 16384 + (a % 16384);
  endfunction

  function automatic int exp_ram_addr(int a);
    return ((m_mode ? m_bank2 : 0) & int'(ram_mask)) * 8192 + (a % 8192);
  endfunction

  function automatic bit in_ram_win(int a);
    return (a >= 'hA000) && (a < 'hC000);
  endfunction

  function automatic logic [7:0] exp_do(int a);
    if (a < 'h8000) return rom_data(exp_rom(a));
    if (in_ram_win(a) && m_ram_en != 0 && ram_present) return model_ram[exp_ram_addr(a)];
    return 8'hFF;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    chk++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ram_en = 0; m_bank1 = 0; m_bank2 = 0; m_mode = 0;
  endtask

  task automatic model_write(int a, int d);
    case (a / 8192)
      0: m_ram_en = ((d % 16) == 10) ? 1 : 0;
      1: m_bank1  = d % 32;
      2: m_bank2  = d % 4;
      3: m_mode   = d % 2;
      default: ;
    endcase
  endtask

  // Write strobe of n cycles; data switches from d0 to d1 halfway through.
  task automatic do_write(int a, int d0, int d1, int n);
    int  d;
    bit  we_exp;
    @(negedge clk);
    cart_addr = 16'(a); cart_di = 8'(d0); cart_wr = 1'b1; cart_rd = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = (i >= n / 2 && n > 1) ? d1 : d0;
      cart_di = 8'(d);
      #1;
      we_exp = in_ram_win(a) && m_ram_en != 0 && ram_present;
      check("wr_ram_we", 32'(ram_we), 32'(we_exp));
      if (we_exp) check("wr_ram_addr", 32'(ram_addr), 32'(exp_ram_addr(a)));
      if (a < 'h8000) check("wr_rom_addr", 32'(rom_addr), 32'(exp_rom(a)));
      @(posedge clk);
      if (i == 0) model_write(a, d0);
      if (we_exp) model_ram[exp_ram_addr(a)] = 8'(d);
      @(negedge clk);
    end
    cart_wr = 1'b0;
  endtask

  task automatic do_read(int a);
    logic [7:0] e;
    @(negedge clk);
    cart_addr = 16'(a); cart_rd = 1'b1; cart_wr = 1'b0;
    #1;
    check("rd_rom_rd", 32'(rom_rd), 32'(a < 'h8000));
    if (a < 'h8000) check("rd_rom_addr", 32'(rom_addr), 32'(exp_rom(a)));
    if (in_ram_win(a) && m_ram_en != 0 && ram_present)
      check("rd_ram_addr", 32'(ram_addr), 32'(exp_ram_addr(a)));
    e = exp_do(a);
    @(negedge clk);
    check("rd_cart_do", 32'(cart_do), 32'(e));
    cart_rd = 1'b0;
  endtask

  initial begin
    int op, a, d, n;
    for (int i = 0; i < 32768; i++) begin
      model_ram[i] = 8'h00;
      ram_mem[i]   = 8'h00;
    end
    model_reset();
    reset = 1'b1; cart_addr = 16'h4000; cart_rd = 1'b1; cart_wr = 1'b0;
    cart_di = 8'h00; rom_mask = 7'h7F; ram_mask = 2'b00; ram_present = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cart_do", 32'(cart_do), 32'hFF);
    check("rst_rom_rd", 32'(rom_rd), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    reset = 1'b0; cart_rd = 1'b0;

    // default mapping
    do_read('h4000);
    check("reset_bank1", 32'(rom_addr), 32'h004000);
    do_read('h0000);

    // bank1 zero test across all five bits
    do_write('h2000, 'h00, 'h00, 1); do_read('h4000);
    do_write('h2000, 'h20, 'h20, 1); do_read('h4000);
    check("bank1_20", 32'(rom_addr), 32'h004000);
    do_write('h2000, 'h1F, 'h1F, 1); do_read('h4000);
    check("bank1_1f", 32'(rom_addr), 32'h07C000);

    // bank2 / mode 1 and mask wrap
    do_write('h4000, 'h02, 'h02, 1);
    do_write('h2000, 'h05, 'h05, 1);
    do_write('h6000, 'h01, 'h01, 1);
    do_read('h0000);
    check("mode1_lo", 32'(rom_addr), 32'h100000);
    do_read('h4123);
    check("mode1_hi", 32'(rom_addr), 32'h114123);
    rom_mask = 7'h3F;
    do_read('h4000);
    check("mask_wrap", 32'(rom_addr), 32'h014000);
    rom_mask = 7'h7F;

    // RAM disabled, then enabled with bank 3
    do_write('hA123, 'h55, 'h55, 3);
    do_read('hA123);
    do_write('h0000, 'h0A, 'h0A, 1);
    do_write('h4000, 'h03, 'h03, 1);
    ram_mask = 2'b11;
    do_write('hA123, 'h5A, 'h5A, 3);
    do_read('hA123);
    check("ram_addr_6123", 32'(ram_addr), 32'h6123);

    // long strobe, data changes mid-strobe: only the edge value counts
    do_write('h2000, 'h03, 'h07, 4);
    do_read('h4000);

    // reset pulse in the middle of a held write strobe
    @(negedge clk);
    cart_addr = 16'h2000; cart_di = 8'h0C; cart_wr = 1'b1;
    @(posedge clk); model_write('h2000, 'h0C);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_reset();
    @(negedge clk);
    check("midrst_cart_do", 32'(cart_do), 32'hFF);
    reset = 1'b0; cart_di = 8'h0E;
    @(posedge clk);
    @(negedge clk); cart_wr = 1'b0;
    do_read('h4000);
    do_read('h0000);
    do_read('hA123);

    // random operations against the model
    for (int k = 0; k < 400; k++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        a = int'($urandom_range(0, 7)) * 8192 + int'($urandom_range(0, 8191));
        d = ($urandom_range(0, 2) == 0) ? 'h0A : int'($urandom_range(0, 255));
        n = int'($urandom_range(1, 3));
        do_write(a, d, int'($urandom_range(0, 255)), n);
      end else if (op <= 7) begin
        if ($urandom_range(0, 2) == 0) a = 'hA000 + int'($urandom_range(0, 8191));
        else a = int'($urandom_range(0, 65535));
        do_read(a);
      end else if (op == 8) begin
        rom_mask = 7'($urandom_range(0, 127));
        ram_mask = 2'($urandom_range(0, 3));
      end else begin
        ram_present = 1'($urandom_range(0, 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
